mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the CPU instruction-fetch port and the load/store data port.
- Accepts at most one transaction at a time and drives a req/ack handshake to the memory.
- Returns a registered read-data / write-done pulse to the owning requester.
- Data port has priority; a starvation limit guarantees fetch progress. Sits between the core datapath and the memory macro.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_sat_counter.sv | 28 ++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam int DEF_STARVE_LIM = 4;
  localparam int DEF_TIMEOUT    = 64;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when the limit is held.
module arb_sat_counter #(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_lim
);

  localparam int W = (LIM < 1) ? 1 : $clog2(LIM + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != W'(LIM))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_lim = (cnt_q == W'(LIM));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port unified memory with starvation guard and timeout flag.
// Optional stall counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_LIM = DEF_STARVE_LIM,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt_o,
  output logic [31:0]       d_stall_cnt_o
`endif
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and grant
  // WAIT  | mem_req_o held until mem_ack_i
  // RESP  | owner's rvalid pulse

  state_e              state_q, state_d;
  owner_e              owner_q;
  logic [ADDR_W-3:0]   addr_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [31:0]         if_rdata_q, d_rdata_q;
  logic                if_rvalid_q, d_rvalid_q;
  logic                err_q;
  logic                if_gnt, d_gnt, mem_req;
  logic                starve_at_lim, to_at_lim;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^{if_addr_i[1:0], d_addr_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_i && !(if_req_i && starve_at_lim)) begin
          d_gnt   = 1'b1;
          state_d = WAIT;
        end else if (if_req_i) begin
          if_gnt  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        if (mem_ack_i) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counts data grants won while fetch was waiting; at the limit fetch goes first.
  arb_sat_counter #(.LIM(STARVE_LIM)) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state_q == IDLE) && (if_gnt || !if_req_i)),
    .inc    (d_gnt && if_req_i),
    .at_lim (starve_at_lim)
  );

  // Counting starts on the grant edge, so the count equals the WAIT cycle index.
  arb_sat_counter #(.LIM(TIMEOUT - 1)) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_d != WAIT),
    .inc    (state_d == WAIT),
    .at_lim (to_at_lim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= FETCH;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (d_gnt) begin
        owner_q <= DATA;
        addr_q  <= d_addr_i[ADDR_W-1:2];
        we_q    <= d_we_i;
        wdata_q <= d_wdata_i;
      end else if (if_gnt) begin
        owner_q <= FETCH;
        addr_q  <= if_addr_i[ADDR_W-1:2];
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
      if ((state_q == WAIT) && mem_ack_i) begin
        if (owner_q == DATA) begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= we_q ? 32'h0 : mem_rdata_i;
        end else begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= mem_rdata_i;
        end
      end
      if ((state_q == WAIT) && !mem_ack_i && to_at_lim) err_q <= 1'b1;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign d_gnt_o     = d_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] if_stall_q, d_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_stall_q <= '0;
      d_stall_q  <= '0;
    end else begin
      if (if_req_i && !if_rvalid_q) if_stall_q <= if_stall_q + 32'd1;
      if (d_req_i && !d_rvalid_q)   d_stall_q  <= d_stall_q + 32'd1;
    end
  end

  assign if_stall_cnt_o = if_stall_q;
  assign d_stall_cnt_o  = d_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters, perf counters off).
module tb_mem_arbiter;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              if_gnt_o, if_rvalid_o;
  logic [31:0]       if_rdata_o;
  logic              d_req_i = 1'b0;
  logic              d_we_i = 1'b0;
  logic [ADDR_W-1:0] d_addr_i = '0;
  logic [31:0]       d_wdata_i = '0;
  logic              d_gnt_o, d_rvalid_o;
  logic [31:0]       d_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-3:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i = 1'b0;
  logic [31:0]       mem_rdata_i = '0;
  logic              busy_o, err_o;

  int vec  = 0;
  int miss = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_rvalid", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
    tick;
    rst = 1'b1;

    // single fetch, ack at first WAIT cycle
    tick;
    if_req_i = 1'b1; if_addr_i = 8'h10;
    #2;
    chk("f1_if_gnt", 32'(if_gnt_o), 32'd1);
    chk("f1_d_gnt", 32'(d_gnt_o), 32'd0);
    chk("f1_req_c0", 32'(mem_req_o), 32'd0);
    tick;
    if_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h00A00093;
    #2;
    chk("f1_mem_req", 32'(mem_req_o), 32'd1);
    chk("f1_mem_addr", 32'(mem_addr_o), 32'h04);
    chk("f1_mem_we", 32'(mem_we_o), 32'd0);
    chk("f1_busy", 32'(busy_o), 32'd1);
    tick;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #2;
    chk("f1_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("f1_rdata", if_rdata_o, 32'h00A00093);
    chk("f1_d_rvalid", 32'(d_rvalid_o), 32'd0);
    tick;
    #2;
    chk("f1_rvalid_off", 32'(if_rvalid_o), 32'd0);
    chk("f1_idle", 32'(busy_o), 32'd0);
    chk("f1_rdata_hold", if_rdata_o, 32'h00A00093);

    // simultaneous requests: data first, fetch right after d_rvalid
    if_req_i = 1'b1; if_addr_i = 8'h14;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 8'h20;
    #1;
    chk("s_d_gnt", 32'(d_gnt_o), 32'd1);
    chk("s_if_gnt", 32'(if_gnt_o), 32'd0);
    tick;
    d_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    #2;
    chk("s_mem_addr", 32'(mem_addr_o), 32'h08);
    chk("s_no_gnt_wait", 32'(if_gnt_o), 32'd0);
    tick;
    mem_ack_i = 1'b0;
    #2;
    chk("s_d_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("s_d_rdata", d_rdata_o, 32'h12345678);
    chk("s_no_gnt_resp", 32'(if_gnt_o), 32'd0);
    tick;
    #2;
    chk("s_if_gnt_after", 32'(if_gnt_o), 32'd1);
    tick;
    if_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    #2;
    chk("s_f_addr", 32'(mem_addr_o), 32'h05);
    tick;
    mem_ack_i = 1'b0;
    #2;
    chk("s_if_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("s_if_rdata", if_rdata_o, 32'hCAFEF00D);
    chk("s_d_rdata_hold", d_rdata_o, 32'h12345678);
    tick;

    // starvation: both held, ack held high; 4 data, 1 fetch, then data
    if_req_i = 1'b1; if_addr_i = 8'h30;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 8'h24;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("starve_d_gnt_%0d", k), 32'(d_gnt_o), (k == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve_if_gnt_%0d", k), 32'(if_gnt_o), (k == 4) ? 32'd1 : 32'd0);
      tick; tick; tick;
    end
    if_req_i = 1'b0; d_req_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h55555555;
    tick;

    // store: latched values held through WAIT, d_rdata returns 0
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 8'h40; d_wdata_i = 32'hDEADBEEF;
    #2;
    chk("st_d_gnt", 32'(d_gnt_o), 32'd1);
    tick;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 8'h00; d_wdata_i = 32'h0;
    #2;
    chk("st_mem_req", 32'(mem_req_o), 32'd1);
    chk("st_mem_we", 32'(mem_we_o), 32'd1);
    chk("st_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("st_mem_addr", 32'(mem_addr_o), 32'h10);
    tick;
    mem_ack_i = 1'b1;
    #2;
    chk("st_mem_we_hold", 32'(mem_we_o), 32'd1);
    chk("st_mem_addr_hold", 32'(mem_addr_o), 32'h10);
    tick;
    mem_ack_i = 1'b0;
    #2;
    chk("st_d_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("st_d_rdata", d_rdata_o, 32'h0);
    tick;
    #2;
    chk("st_d_rvalid_off", 32'(d_rvalid_o), 32'd0);

    // timeout: no ack; err rises in WAIT cycle 64 and sticks
    if_req_i = 1'b1; if_addr_i = 8'h80;
    #1;
    chk("to_if_gnt", 32'(if_gnt_o), 32'd1);
    tick;
    if_req_i = 1'b0;
    for (int c = 1; c < 63; c++) tick;
    #2;
    chk("to_err_c63", 32'(err_o), 32'd0);
    chk("to_req_c63", 32'(mem_req_o), 32'd1);
    tick;
    #2;
    chk("to_err_c64", 32'(err_o), 32'd1);
    chk("to_busy_c64", 32'(busy_o), 32'd1);
    for (int c = 0; c < 5; c++) tick;
    #2;
    chk("to_err_sticky", 32'(err_o), 32'd1);
    chk("to_req_still", 32'(mem_req_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    chk("arst_if_rdata", if_rdata_o, 32'h0);
    tick;
    rst = 1'b1;
    tick;
    #2;
    chk("post_rst_err", 32'(err_o), 32'd0);
    chk("post_rst_idle", 32'(busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
